// File: rtl/block_memory_if.sv
// Request/response handshake between the L1 cache (master) and block_memory (slave).
// The shared tri-state dataM bus is a separate inout port on block_memory, not part of this bundle.
interface block_memory_if #(
  parameter int WORD_SIZE = 16
);
  logic                 readM;
  logic                 writeM;
  logic [WORD_SIZE-1:0] address;
  logic                 input_readyM;
  logic                 doneM;
  logic [WORD_SIZE-1:0] num_mem_reads;
  logic [WORD_SIZE-1:0] num_mem_writes;

  modport master (
    output readM, writeM, address,
    input  input_readyM, doneM, num_mem_reads, num_mem_writes
  );

  modport slave (
    input  readM, writeM, address,
    output input_readyM, doneM, num_mem_reads, num_mem_writes
  );
endinterface

// File: rtl/block_memory.sv
// Latency-modelled main memory behind the L1 cache: one request at a time, fixed
// access latency, one-cycle response pulse. Block mode moves 4-word lines, word mode one word.
module block_memory #(
  parameter int WORD_SIZE  = 16,
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 8,
  parameter int BYPASS     = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  block_memory_if.slave          bus,
  inout  wire [4*WORD_SIZE-1:0]  dataM
);

  localparam int         LINE_W   = 4 * WORD_SIZE;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  wr_q;
  logic [DEPTH_LOG2-1:0] blk_q;
  logic [1:0]            off_q;
  logic [LINE_W-1:0]     wdata_q;
  logic [LINE_W-1:0]     rdata_q;
  logic                  ready_q;
  logic                  done_q;
  logic [WORD_SIZE-1:0]  nrd_q;
  logic [WORD_SIZE-1:0]  nwr_q;

  // Storage is intentionally left out of reset so benches can preload it.
  logic [LINE_W-1:0]     mem_q [2**DEPTH_LOG2];

  logic                  commit_d;
  logic [LINE_W-1:0]     wline_d;
  logic [LINE_W-1:0]     rline_d;
  logic                  unused_addr_d;

  assign unused_addr_d = ^bus.address[WORD_SIZE-1:DEPTH_LOG2+2];

  // Write commits on the final BUSY edge; a reset on that edge drops it.
  assign commit_d = (state_q == BUSY) && (cnt_q == 4'd0) && wr_q && reset_n;

  // Merge incoming write data into the stored line and shape the read line.
  always_comb begin
    wline_d = mem_q[blk_q];
    rline_d = mem_q[blk_q];
    if (BYPASS != 0) begin
      wline_d[off_q*WORD_SIZE +: WORD_SIZE] = wdata_q[WORD_SIZE-1:0];
      rline_d = '0;
      rline_d[WORD_SIZE-1:0] = mem_q[blk_q][off_q*WORD_SIZE +: WORD_SIZE];
    end else begin
      wline_d = wdata_q;
      rline_d = mem_q[blk_q];
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (commit_d) begin
      mem_q[blk_q] <= wline_d;
    end
  end

  // Request FSM with registered response pulses and access counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      blk_q   <= '0;
      off_q   <= 2'd0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      nrd_q   <= '0;
      nwr_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // Write wins over a simultaneous read; the read is simply dropped.
          if (bus.writeM || bus.readM) begin
            wr_q    <= bus.writeM;
            blk_q   <= bus.address[DEPTH_LOG2+1:2];
            off_q   <= bus.address[1:0];
            wdata_q <= dataM;
            cnt_q   <= CNT_INIT;
            state_q <= BUSY;
            if (bus.writeM) begin
              nwr_q <= nwr_q + 1'b1;
            end else begin
              nrd_q <= nrd_q + 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            ready_q <= !wr_q;
            done_q  <= wr_q;
            if (!wr_q) begin
              rdata_q <= rline_d;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Drive enable is the registered ready flag, so data is valid for the whole pulse.
  assign dataM              = ready_q ? rdata_q : {LINE_W{1'bz}};
  assign bus.input_readyM   = ready_q;
  assign bus.doneM          = done_q;
  assign bus.num_mem_reads  = nrd_q;
  assign bus.num_mem_writes = nwr_q;

endmodule
